sha256_msg_sched: RTL and testbench

- Message-schedule and control source for the SHA-256 compression block (MC); it drives MC's data_in, FSM_core_in and core_count_in.
- Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready handshake.
- Streams W[0..63], one word per cycle, with the compress code and round index, then issues the 8-cycle hash-read sequence.
- Sits between the padding/word-packer front end and MC.

---
 rtl/sha256_msg_sched.sv | 203 ++++++++++++++++++++
 tb/tb_sha256_msg_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// ============================================================================
// sha256_msg_sched
//
// Message-schedule and control source for the SHA-256 compression block (MC).
// It takes one 512-bit block as 16 big-endian 32-bit words over a valid/ready
// handshake. It then streams W[0..63], one word per cycle, with the compress
// code and the round index, and finally issues the 8-cycle hash-read sequence.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   block_word_in   message word M[i]; the first accepted word is M[0]
//   block_dv_in     block_word_in is valid
//   block_rdy_out   a word is accepted this cycle if block_dv_in is high
//   data_out        W[t] to MC data_in
//   FSM_core_out    to MC FSM_core_in: 000 idle, 001 load, 011 compress,
//                   100 read hash
//   core_count_out  to MC core_count_in: round t in compress, hash index
//                   in read
//   sched_dv_out    high while data_out carries a valid W[t]
//   done_out        one-cycle pulse in the cycle after the last read cycle
//   err_out         (only with SHA256_SCHED_ERR_EN) sticky flag that is set
//                   when data is presented during compress or read
//
// Optional feature macro: SHA256_SCHED_ERR_EN
// ============================================================================
module sha256_msg_sched #(
    parameter int DATA_WIDTH = 32,
    parameter int ROUNDS     = 64,
    parameter int HASH_WORDS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] block_word_in,
    input  logic                  block_dv_in,
    output logic                  block_rdy_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [2:0]            FSM_core_out,
    output logic [6:0]            core_count_out,
    output logic                  sched_dv_out,
    output logic                  done_out
`ifdef SHA256_SCHED_ERR_EN
   ,output logic                  err_out
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMP,
        S_READ
    } state_t;

    localparam logic [2:0] CODE_IDLE = 3'b000;
    localparam logic [2:0] CODE_LOAD = 3'b001;
    localparam logic [2:0] CODE_COMP = 3'b011;
    localparam logic [2:0] CODE_READ = 3'b100;

    localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);
    localparam logic [6:0] LAST_HASH  = 7'(HASH_WORDS - 1);

    // ------------------------------------------------------------------------
    // SHA-256 small sigma functions (word width is fixed at 32)
    // ------------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] sigma0(input logic [DATA_WIDTH-1:0] x);
        sigma0 = {x[6:0],  x[DATA_WIDTH-1:7]}  ^
                 {x[17:0], x[DATA_WIDTH-1:18]} ^
                 {3'b000,  x[DATA_WIDTH-1:3]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] sigma1(input logic [DATA_WIDTH-1:0] x);
        sigma1 = {x[16:0], x[DATA_WIDTH-1:17]} ^
                 {x[18:0], x[DATA_WIDTH-1:19]} ^
                 {10'd0,   x[DATA_WIDTH-1:10]};
    endfunction

    state_t                state;
    logic [3:0]            load_cnt;
    logic [DATA_WIDTH-1:0] win [16];
    logic [DATA_WIDTH-1:0] w_next;
    logic                  accept;
    logic                  shift_en;
    logic [DATA_WIDTH-1:0] shift_in;

    assign accept = block_dv_in && block_rdy_out;

    // The window holds the 16 upcoming words W[t..t+15] while compressing.
    // win[0] is the word currently shown on data_out. win[1] is the next word
    // to register, and W[t+16] is formed from the window and shifted in.
    // During loading the same shift path takes M[0..15], so M[0] sits in
    // win[1] at the moment M[15] is accepted.
    assign w_next = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];

    always_comb begin
        shift_en = 1'b0;
        shift_in = block_word_in;
        case (state)
            S_IDLE, S_LOAD: shift_en = accept;
            S_COMP: begin
                shift_en = (core_count_out != LAST_ROUND);
                shift_in = w_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (shift_en) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= shift_in;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            load_cnt       <= '0;
            data_out       <= '0;
            FSM_core_out   <= CODE_IDLE;
            core_count_out <= '0;
            sched_dv_out   <= 1'b0;
            done_out       <= 1'b0;
            block_rdy_out  <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Ready rises on the first edge after reset release.
                    block_rdy_out <= 1'b1;
                    FSM_core_out  <= CODE_IDLE;
                    if (accept) begin
                        load_cnt     <= 4'd1;
                        state        <= S_LOAD;
                        FSM_core_out <= CODE_LOAD;
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        if (load_cnt == 4'd15) begin
                            // M[15] accepted: the first compress cycle shows W[0].
                            state          <= S_COMP;
                            block_rdy_out  <= 1'b0;
                            FSM_core_out   <= CODE_COMP;
                            data_out       <= win[1];
                            sched_dv_out   <= 1'b1;
                            core_count_out <= '0;
                            load_cnt       <= '0;
                        end else begin
                            load_cnt <= load_cnt + 4'd1;
                        end
                    end
                end

                S_COMP: begin
                    if (core_count_out == LAST_ROUND) begin
                        state          <= S_READ;
                        FSM_core_out   <= CODE_READ;
                        data_out       <= '0;
                        sched_dv_out   <= 1'b0;
                        core_count_out <= '0;
                    end else begin
                        core_count_out <= core_count_out + 7'd1;
                        data_out       <= win[1];
                    end
                end

                S_READ: begin
                    if (core_count_out == LAST_HASH) begin
                        // Back in idle: ready and done rise together, so the
                        // next block's M[0] can be taken in this same cycle.
                        state          <= S_IDLE;
                        FSM_core_out   <= CODE_IDLE;
                        core_count_out <= '0;
                        done_out       <= 1'b1;
                        block_rdy_out  <= 1'b1;
                    end else begin
                        core_count_out <= core_count_out + 7'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SHA256_SCHED_ERR_EN
    // Sticky flag: data was presented while the block was not accepting words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_out <= 1'b0;
        end else if (block_dv_in && (state == S_COMP || state == S_READ)) begin
            err_out <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// ============================================================================
// tb_sha256_msg_sched
//
// Self-checking bench for sha256_msg_sched. A behavioural model builds the
// full expected output timeline of each block from the SHA-256 schedule
// formula. One compare process checks every DUT output on every falling edge.
// With SHA256_SCHED_ERR_EN defined, the bench also checks err_out.
// ============================================================================
module tb_sha256_msg_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] block_word_in;
    logic        block_dv_in;
    logic        block_rdy_out;
    logic [31:0] data_out;
    logic [2:0]  FSM_core_out;
    logic [6:0]  core_count_out;
    logic        sched_dv_out;
    logic        done_out;
`ifdef SHA256_SCHED_ERR_EN
    logic        err_out;
`endif

    always #5 clk = ~clk;

    sha256_msg_sched #(.DATA_WIDTH(32), .ROUNDS(64), .HASH_WORDS(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .block_word_in  (block_word_in),
        .block_dv_in    (block_dv_in),
        .block_rdy_out  (block_rdy_out),
        .data_out       (data_out),
        .FSM_core_out   (FSM_core_out),
        .core_count_out (core_count_out),
        .sched_dv_out   (sched_dv_out),
        .done_out       (done_out)
`ifdef SHA256_SCHED_ERR_EN
       ,.err_out        (err_out)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic void calc_w(input logic [31:0] m [16], output logic [31:0] w [64]);
        for (int t = 0; t < 16; t++) w[t] = m[t];
        for (int t = 16; t < 64; t++)
            w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
    endfunction

    typedef struct packed {
        logic [2:0]  fsm;
        logic [6:0]  cnt;
        logic [31:0] data;
        logic        dv;
        logic        done;
        logic        rdy;
    } exp_t;

    exp_t        sched_q[$];
    exp_t        exp_cur = '0;
    logic        exp_err = 1'b0;
    logic [31:0] mbuf [16];
    logic [31:0] wexp [64];
    int          nwords   = 0;
    int          cyc      = 0;
    int          dv_cnt   = 0;
    int          first_neg = 0;
    int          m15_neg   = 0;

    // Compare, then advance the model using the inputs that the next rising
    // edge will sample.
    always @(negedge clk) begin
        exp_t nx;
        logic acc;
        logic built;
        cyc++;
        if (!rst_n) begin
            exp_cur = '0;
            exp_err = 1'b0;
        end
        chk("fsm",      {29'd0, FSM_core_out},   {29'd0, exp_cur.fsm});
        chk("count",    {25'd0, core_count_out}, {25'd0, exp_cur.cnt});
        chk("data",     data_out,                exp_cur.data);
        chk("sched_dv", {31'd0, sched_dv_out},   {31'd0, exp_cur.dv});
        chk("done",     {31'd0, done_out},       {31'd0, exp_cur.done});
        chk("rdy",      {31'd0, block_rdy_out},  {31'd0, exp_cur.rdy});
`ifdef SHA256_SCHED_ERR_EN
        chk("err",      {31'd0, err_out},        {31'd0, exp_err});
`endif
        if (!rst_n) begin
            sched_q.delete();
            nwords = 0;
            dv_cnt = 0;
        end else begin
            if (sched_dv_out) dv_cnt++;
            if (done_out) begin
                chk("dv_cycles", dv_cnt, 64);
                chk("done_latency", cyc - m15_neg, 72);
                if (m15_neg - first_neg == 15)
                    chk("total_cycles", cyc - first_neg + 1, 88);
                dv_cnt = 0;
            end
            if (block_dv_in && (exp_cur.fsm == 3'b011 || exp_cur.fsm == 3'b100))
                exp_err = 1'b1;
            acc   = block_dv_in && exp_cur.rdy;
            built = 1'b0;
            if (sched_q.size() > 0) begin
                nx = sched_q.pop_front();
                built = 1'b1;
            end else begin
                nx = '0;
                nx.rdy = 1'b1;
                if (acc) begin
                    if (nwords == 0) first_neg = cyc + 1;
                    mbuf[nwords] = block_word_in;
                    nwords++;
                    if (nwords == 16) begin
                        exp_t e;
                        calc_w(mbuf, wexp);
                        for (int t = 0; t < 64; t++) begin
                            e = '0; e.fsm = 3'b011; e.cnt = 7'(t); e.data = wexp[t]; e.dv = 1'b1;
                            sched_q.push_back(e);
                        end
                        for (int i = 0; i < 8; i++) begin
                            e = '0; e.fsm = 3'b100; e.cnt = 7'(i);
                            sched_q.push_back(e);
                        end
                        e = '0; e.done = 1'b1; e.rdy = 1'b1;
                        sched_q.push_back(e);
                        nwords  = 0;
                        m15_neg = cyc + 1;
                        nx = sched_q.pop_front();
                        built = 1'b1;
                    end
                end
                if (!built) nx.fsm = (nwords > 0) ? 3'b001 : 3'b000;
            end
            exp_cur = nx;
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_block(input logic [31:0] m [16], input int n, input int gap_pct,
                              input bit keep_dv);
        bit ok;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                block_dv_in   = 1'b0;
                block_word_in = $urandom;
                @(posedge clk); #1;
            end
            block_dv_in   = 1'b1;
            block_word_in = m[i];
            ok = 1'b0;
            for (int k = 0; k < 300 && !ok; k++) begin
                @(negedge clk);
                if (block_rdy_out === 1'b1) ok = 1'b1;
                else begin @(posedge clk); #1; end
            end
            if (!ok) begin
                chk("accept_timeout", 32'd0, 32'd1);
                block_dv_in = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        if (!keep_dv) block_dv_in = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done_out === 1'b1) seen = 1'b1;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int cycles);
        rst_n       = 1'b0;
        block_dv_in = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    logic [31:0] abc [16];
    logic [31:0] blk [16];
    logic [31:0] wchk [64];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        block_dv_in   = 1'b0;
        block_word_in = '0;
        for (int i = 0; i < 16; i++) abc[i] = 32'h0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        // Hand-computed pins on the model itself.
        calc_w(abc, wchk);
        chk("model_W15", wchk[15], 32'h00000018);
        chk("model_W16", wchk[16], 32'h61626380);
        chk("model_W17", wchk[17], 32'h000f0000);
        chk("model_W18", wchk[18], 32'h7da86405);

        // Power-on reset for two cycles.
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset asserted mid-load after 5 words.
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        send_block(blk, 5, 0, 1'b0);
        do_reset(2);

        // "abc" block fed back-to-back, with literal check of first compress cycle.
        send_block(abc, 16, 0, 1'b0);
        @(negedge clk);
        chk("abc_first_data", data_out, 32'h61626380);
        chk("abc_first_cnt", {25'd0, core_count_out}, 32'd0);
        chk("abc_first_fsm", {29'd0, FSM_core_out}, 32'd3);
        wait_done();

        // Same block with random gaps during load.
        send_block(abc, 16, 40, 1'b0);
        wait_done();

        // Random blocks with random gaps.
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            send_block(blk, 16, 30, 1'b0);
            wait_done();
        end

        // Valid held high through compress/read; second block taken at done.
        send_block(abc, 16, 0, 1'b1);
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        send_block(blk, 16, 0, 1'b0);
        wait_done();
`ifdef SHA256_SCHED_ERR_EN
        chk("err_sticky", {31'd0, err_out}, 32'd1);
`endif

        // Reset in the middle of compress aborts the block with no done.
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        send_block(blk, 16, 0, 1'b0);
        repeat (20) @(posedge clk);
        #1 do_reset(2);
        repeat (100) @(posedge clk);
        #1;

        // One more block after the abort.
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        send_block(blk, 16, 20, 1'b0);
        wait_done();
        repeat (4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
